// File: rtl/split_slave_port_pkg.sv
// Shared definitions for the split-capable serial slave port:
// frame mode encoding, FSM state type and default widths.
package split_slave_port_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;
    localparam int CNT_W      = 4;

    localparam logic MODE_RD = 1'b0;
    localparam logic MODE_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_ADDR,
        ST_RX_WDATA,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_SPLIT_BUSY,
        ST_SPLIT_DONE,
        ST_TX
    } slave_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/split_slave_port_shifter.sv
// Width-W shift register, LSB-first in and out, with a bit counter whose
// last_o flags the shift that completes a W-bit word.
module split_slave_port_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         sin_i,
    output logic [W-1:0] data_o,
    output logic         last_o
);

    localparam int             CW   = $clog2(W + 1);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        last_o = shift_i && (cnt_q == LAST);
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            data_d = {sin_i, data_q[W-1:1]};
            cnt_d  = last_o ? '0 : cnt_q + 1'b1;
        end else if (clr_i) begin
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/split_slave_port.sv
// Serial bus slave port: decodes mode/address/data frames, runs the local
// memory access and splits slow reads off the bus via split_req/split_ack.
//   state      | meaning
//   IDLE       | waiting for the mode bit of a selected frame
//   RX_ADDR    | shifting in address bits
//   RX_WDATA   | shifting in write data bits
//   MEM_WR     | write strobe held until mem_ready
//   MEM_RD     | read strobe held, wait counter running toward split
//   SPLIT_BUSY | split_req high; read completes, minimum hold enforced
//   SPLIT_DONE | bus released, waiting for controller split_ack
//   TX         | streaming read data LSB first
module split_slave_port
    import split_slave_port_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter bit SPLIT_EN      = 1'b1,
    parameter int SPLIT_THRESH  = 4,
    parameter int MIN_SPLIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              bus_sel,
    input  logic              bus_din,
    input  logic              bus_din_valid,
    output logic              bus_dout,
    output logic              bus_dout_valid,
    output logic              slave_ready,
    output logic              split_req,
    input  logic              split_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(SPLIT_THRESH - 1);
    localparam logic [CNT_W-1:0] MIN_M1    =
        CNT_W'((MIN_SPLIT_CYC > 0) ? MIN_SPLIT_CYC - 1 : 0);

    slave_state_e     state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;
    logic             rd_done_q, rd_done_d;
    logic             ack_pend_q, ack_pend_d;

    logic              frame_clr;
    logic              addr_shift, addr_last;
    logic              wdata_shift, wdata_last;
    logic              tx_load, tx_shift, tx_last;
    logic [DATA_W-1:0] tx_data;
    logic              bit_v;

    assign bit_v = bus_sel & bus_din_valid;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        wait_cnt_d     = '0;
        split_cnt_d    = '0;
        rd_done_d      = 1'b0;
        ack_pend_d     = 1'b0;
        frame_clr      = 1'b0;
        addr_shift     = 1'b0;
        wdata_shift    = 1'b0;
        tx_load        = 1'b0;
        tx_shift       = 1'b0;
        mem_wr         = 1'b0;
        mem_rd         = 1'b0;
        split_req      = 1'b0;
        slave_ready    = 1'b0;
        bus_dout_valid = 1'b0;
        bus_dout       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                slave_ready = 1'b1;
                frame_clr   = 1'b1;
                if (bit_v) begin
                    mode_d  = bus_din;
                    state_d = ST_RX_ADDR;
                end
            end
            ST_RX_ADDR: begin
                if (!bus_sel) begin
                    state_d = ST_IDLE;
                end else if (bus_din_valid) begin
                    addr_shift = 1'b1;
                    if (addr_last) begin
                        state_d = (mode_q == MODE_WR) ? ST_RX_WDATA : ST_MEM_RD;
                    end
                end
            end
            ST_RX_WDATA: begin
                if (!bus_sel) begin
                    state_d = ST_IDLE;
                end else if (bus_din_valid) begin
                    wdata_shift = 1'b1;
                    if (wdata_last) begin
                        state_d = ST_MEM_WR;
                    end
                end
            end
            ST_MEM_WR: begin
                mem_wr = 1'b1;
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_RD: begin
                mem_rd = 1'b1;
                // A ready arriving on the threshold cycle takes priority over splitting.
                if (mem_ready) begin
                    tx_load = 1'b1;
                    state_d = ST_TX;
                end else if (SPLIT_EN && (wait_cnt_q >= THRESH_M1)) begin
                    state_d = ST_SPLIT_BUSY;
                end else begin
                    wait_cnt_d = sat_inc(wait_cnt_q);
                end
            end
            ST_SPLIT_BUSY: begin
                split_req   = 1'b1;
                mem_rd      = !rd_done_q;
                rd_done_d   = rd_done_q;
                split_cnt_d = sat_inc(split_cnt_q);
                if (!rd_done_q && mem_ready) begin
                    tx_load   = 1'b1;
                    rd_done_d = 1'b1;
                end
                if ((rd_done_q || mem_ready) && (split_cnt_q >= MIN_M1)) begin
                    state_d    = ST_SPLIT_DONE;
                    ack_pend_d = split_ack;
                end
            end
            ST_SPLIT_DONE: begin
                if (split_ack || ack_pend_q) begin
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                bus_dout_valid = 1'b1;
                bus_dout       = tx_data[0];
                tx_shift       = 1'b1;
                if (tx_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_RD;
            wait_cnt_q  <= '0;
            split_cnt_q <= '0;
            rd_done_q   <= 1'b0;
            ack_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wait_cnt_q  <= wait_cnt_d;
            split_cnt_q <= split_cnt_d;
            rd_done_q   <= rd_done_d;
            ack_pend_q  <= ack_pend_d;
        end
    end

    split_slave_port_shifter #(.W(ADDR_W)) u_addr_sr (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       (frame_clr),
        .load_i      (1'b0),
        .load_data_i ({ADDR_W{1'b0}}),
        .shift_i     (addr_shift),
        .sin_i       (bus_din),
        .data_o      (mem_addr),
        .last_o      (addr_last)
    );

    split_slave_port_shifter #(.W(DATA_W)) u_wdata_sr (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       (frame_clr),
        .load_i      (1'b0),
        .load_data_i ({DATA_W{1'b0}}),
        .shift_i     (wdata_shift),
        .sin_i       (bus_din),
        .data_o      (mem_wdata),
        .last_o      (wdata_last)
    );

    split_slave_port_shifter #(.W(DATA_W)) u_tx_sr (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       (1'b0),
        .load_i      (tx_load),
        .load_data_i (mem_rdata),
        .shift_i     (tx_shift),
        .sin_i       (1'b0),
        .data_o      (tx_data),
        .last_o      (tx_last)
    );

    // Upper TX bits only ever move down toward bit 0.
    logic unused_tx_hi;
    assign unused_tx_hi = ^tx_data[DATA_W-1:1];

endmodule

// File: tb/tb_split_slave_port.sv
// Scoreboard bench for split_slave_port: stimulus pushes expected memory
// accesses and TX bits; a negedge monitor pops and compares.
module tb_split_slave_port;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        bus_sel = 1'b0;
    logic        bus_din = 1'b0;
    logic        bus_din_valid = 1'b0;
    logic        bus_dout;
    logic        bus_dout_valid;
    logic        slave_ready;
    logic        split_req;
    logic        split_ack = 1'b0;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] q_wr[$];
    logic [11:0] q_rd[$];
    logic        q_tx[$];

    always #5 clk = ~clk;

    split_slave_port dut (
        .clk            (clk),
        .rstn           (rstn),
        .bus_sel        (bus_sel),
        .bus_din        (bus_din),
        .bus_din_valid  (bus_din_valid),
        .bus_dout       (bus_dout),
        .bus_dout_valid (bus_dout_valid),
        .slave_ready    (slave_ready),
        .split_req      (split_req),
        .split_ack      (split_ack),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wr         (mem_wr),
        .mem_rd         (mem_rd),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT output with no expected entry (t=%0t)", nm, $time);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_wr && mem_ready) begin
                if (q_wr.size() == 0) unexpected("wr_access");
                else chk("wr_addr_data", {mem_addr, mem_wdata}, q_wr.pop_front());
            end
            if (mem_rd && mem_ready) begin
                if (q_rd.size() == 0) unexpected("rd_access");
                else chk("rd_addr", mem_addr, q_rd.pop_front());
            end
            if (bus_dout_valid) begin
                if (q_tx.size() == 0) unexpected("tx_bit");
                else chk("tx_bit", bus_dout, q_tx.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic mode, input logic [11:0] a, input logic [7:0] d);
        bus_sel = 1'b1;
        bus_din_valid = 1'b1;
        bus_din = mode;
        tick();
        for (int i = 0; i < 12; i++) begin
            bus_din = a[i];
            tick();
        end
        if (mode) begin
            for (int i = 0; i < 8; i++) begin
                bus_din = d[i];
                tick();
            end
        end
        bus_sel = 1'b0;
        bus_din_valid = 1'b0;
        bus_din = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 30; k++) begin
            if (slave_ready) break;
            tick();
        end
        chk(nm, slave_ready, 1);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input int dly);
        bit wr_bad = 0;
        bit sp_bad = 0;
        q_wr.push_back({a, d});
        send_frame(1'b1, a, d);
        for (int c = 0; c <= dly; c++) begin
            mem_ready = (c == dly);
            if (!mem_wr) wr_bad = 1;
            if (split_req) sp_bad = 1;
            tick();
        end
        mem_ready = 1'b0;
        chk("wr_strobe_held", wr_bad, 0);
        chk("wr_strobe_drop", mem_wr, 0);
        chk("wr_no_split", sp_bad, 0);
        chk("wr_idle_after", slave_ready, 1);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [7:0] rd, input int dly,
                           input bit exp_split, input int exp_high);
        int rise_c = -1;
        int high_n = 0;
        bit dv_early = 0;
        q_rd.push_back(a);
        for (int i = 0; i < 8; i++) q_tx.push_back(rd[i]);
        send_frame(1'b0, a, 8'h00);
        for (int c = 0; c < 60; c++) begin
            mem_ready = (c == dly);
            mem_rdata = (c == dly) ? rd : 8'h00;
            if (split_req) begin
                if (rise_c < 0) rise_c = c;
                high_n++;
            end
            if (c == dly + 1) begin
                if (!exp_split) begin
                    chk("rd_first_bit_latency", bus_dout_valid, 1);
                    break;
                end
                chk("rd_strobe_drop", mem_rd, 0);
            end
            if (bus_dout_valid) dv_early = 1;
            if (exp_split && c > dly && !split_req) break;
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        if (!exp_split) begin
            chk("rd_no_split", rise_c, -1);
        end else begin
            chk("split_rise_cycle", rise_c, 4);
            chk("split_high_cycles", high_n, exp_high);
            for (int k = 0; k < 3; k++) begin
                if (bus_dout_valid) dv_early = 1;
                tick();
            end
            chk("no_tx_before_ack", dv_early, 0);
            split_ack = 1'b1;
            tick();
            split_ack = 1'b0;
            chk("tx_after_ack", bus_dout_valid, 1);
        end
        wait_idle("rd_done_idle");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit bad;
        // Reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_slave_ready", slave_ready, 1);
        chk("rst_outputs", {bus_dout, bus_dout_valid, split_req, mem_wr, mem_rd}, 5'b0);
        chk("rst_addr_data", {mem_addr, mem_wdata}, 20'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        do_write(12'h0A5, 8'h3C, 2);
        do_read(12'h123, 8'h81, 2, 1'b0, 0);
        do_read(12'h456, 8'hA5, 10, 1'b1, 7);
        do_read(12'h789, 8'hA5, 5, 1'b1, 2);
        do_read(12'h234, 8'h5A, 4, 1'b1, 2);
        do_read(12'h0FF, 8'hC3, 3, 1'b0, 0);

        // Abort: bus_sel dropped after 5 address bits
        bus_sel = 1'b1;
        bus_din_valid = 1'b1;
        bus_din = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_din = i[0];
            tick();
        end
        bus_sel = 1'b0;
        tick();
        bus_din_valid = 1'b0;
        chk("abort_idle", slave_ready, 1);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_rd || mem_wr) bad = 1;
            tick();
        end
        chk("abort_no_access", bad, 0);
        do_read(12'h3C0, 8'h66, 2, 1'b0, 0);

        // Reset during SPLIT_BUSY
        send_frame(1'b0, 12'h0F0, 8'h00);
        for (int k = 0; k < 20; k++) begin
            if (split_req) break;
            tick();
        end
        chk("pre_rst_split_up", split_req, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_async_split_drop", split_req, 0);
        chk("rst_async_rd_drop", mem_rd, 0);
        tick();
        rstn = 1'b1;
        split_ack = 1'b1;
        tick();
        split_ack = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus_dout_valid || split_req || mem_rd) bad = 1;
            tick();
        end
        chk("spurious_ack_ignored", bad, 0);
        chk("post_rst_idle", slave_ready, 1);
        chk("post_rst_addr", mem_addr, 12'h000);

        do_write(12'hFFF, 8'hFF, 0);

        repeat (3) tick();
        chk("wr_queue_drained", q_wr.size(), 0);
        chk("rd_queue_drained", q_rd.size(), 0);
        chk("tx_queue_drained", q_tx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
